// File: rtl/teclado_atm.sv
`default_nettype none
// ============================================================================
// Module   : teclado_atm
// Brief    : ATM keypad front-end: synchronise, debounce, PIN digits, amounts.
// Revision : 1.0
// ============================================================================
module teclado_atm #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int MAX_DIGITOS     = 9
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic [3:0]  Tecla,
   input  logic        Tecla_presionada,
   input  logic        Tarjeta_recibida,
   input  logic        Bloqueo,
   output logic [3:0]  Digito,
   output logic        Digito_STB,
   output logic        Tipo_trans,
   output logic [31:0] Monto,
   output logic        Monto_STB,
   output logic        Error_tecla
);

   localparam logic [7:0] c_deb = 8'(DEBOUNCE_CYCLES);
   localparam logic [3:0] c_max = 4'(MAX_DIGITOS);

   typedef enum logic [1:0] {
      ESPERA  = 2'd0,
      DIGITOS = 2'd1,
      MONTO   = 2'd2
   } estado_t;

   logic [3:0]  r_tecla_s1, r_tecla_s2;
   logic        r_pres_s1, r_pres_s2;
   logic        r_armado;
   logic [7:0]  r_db_cnt;
   logic [3:0]  r_db_code;
   logic [7:0]  w_run;
   logic        w_accept;

   estado_t     r_estado, w_estado_n;
   logic [31:0] r_acc, w_acc_n;
   logic [3:0]  r_cnt, w_cnt_n;
   logic [3:0]  r_digito, w_digito_n;
   logic        r_tipo, w_tipo_n;
   logic [31:0] r_monto, w_monto_n;
   logic        r_dstb, w_dstb_n;
   logic        r_mstb, w_mstb_n;
   logic        r_err, w_err_n;

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_tecla_s1 <= '0;
         r_tecla_s2 <= '0;
         r_pres_s1  <= 1'b0;
         r_pres_s2  <= 1'b0;
      end else begin
         r_tecla_s1 <= Tecla;
         r_tecla_s2 <= r_tecla_s1;
         r_pres_s1  <= Tecla_presionada;
         r_pres_s2  <= r_pres_s1;
      end
   end

   // Length of the current run of pressed samples sharing one code, this sample included.
   always_comb begin
      w_run = 8'd0;
      if (r_pres_s2) begin
         if (r_db_cnt != 8'd0 && r_tecla_s2 == r_db_code)
            w_run = r_db_cnt + 8'd1;
         else
            w_run = 8'd1;
      end
      w_accept = r_armado && (w_run == c_deb);
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_armado  <= 1'b1;
         r_db_cnt  <= '0;
         r_db_code <= '0;
      end else if (r_armado) begin
         r_db_code <= r_tecla_s2;
         if (w_accept) begin
            r_armado <= 1'b0;
            r_db_cnt <= '0;
         end else begin
            r_db_cnt <= w_run;
         end
      end else if (r_pres_s2) begin
         r_db_cnt <= '0;
      end else if (r_db_cnt + 8'd1 == c_deb) begin
         r_armado <= 1'b1;
         r_db_cnt <= '0;
      end else begin
         r_db_cnt <= r_db_cnt + 8'd1;
      end
   end

   always_comb begin
      w_estado_n = r_estado;
      w_acc_n    = r_acc;
      w_cnt_n    = r_cnt;
      w_digito_n = r_digito;
      w_tipo_n   = r_tipo;
      w_monto_n  = r_monto;
      w_dstb_n   = 1'b0;
      w_mstb_n   = 1'b0;
      w_err_n    = 1'b0;
      if (!Tarjeta_recibida) begin
         w_estado_n = ESPERA;
         w_acc_n    = '0;
         w_cnt_n    = '0;
      end else if (r_estado == ESPERA) begin
         w_estado_n = DIGITOS;
      end else if (w_accept && !Bloqueo) begin
         if (r_estado == DIGITOS) begin
            if (r_tecla_s2 <= 4'd9) begin
               w_digito_n = r_tecla_s2;
               w_dstb_n   = 1'b1;
            end else if (r_tecla_s2 == 4'hA || r_tecla_s2 == 4'hB) begin
               w_tipo_n   = r_tecla_s2[0];
               w_acc_n    = '0;
               w_cnt_n    = '0;
               w_estado_n = MONTO;
            end else begin
               w_err_n = 1'b1;
            end
         end else if (r_tecla_s2 <= 4'd9) begin
            if (r_cnt < c_max) begin
               w_acc_n = r_acc * 32'd10 + {28'd0, r_tecla_s2};
               w_cnt_n = r_cnt + 4'd1;
            end else begin
               w_err_n = 1'b1;
            end
         end else begin
            case (r_tecla_s2)
               4'hC: begin
                  w_acc_n = '0;
                  w_cnt_n = '0;
               end
               4'hD: begin
                  w_acc_n    = '0;
                  w_cnt_n    = '0;
                  w_estado_n = DIGITOS;
               end
               4'hE: begin
                  if (r_cnt != 4'd0) begin
                     w_monto_n  = r_acc;
                     w_mstb_n   = 1'b1;
                     w_acc_n    = '0;
                     w_cnt_n    = '0;
                     w_estado_n = DIGITOS;
                  end else begin
                     w_err_n = 1'b1;
                  end
               end
               default: w_err_n = 1'b1;
            endcase
         end
      end
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_estado <= ESPERA;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_digito <= '0;
         r_tipo   <= 1'b0;
         r_monto  <= '0;
         r_dstb   <= 1'b0;
         r_mstb   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_estado <= w_estado_n;
         r_acc    <= w_acc_n;
         r_cnt    <= w_cnt_n;
         r_digito <= w_digito_n;
         r_tipo   <= w_tipo_n;
         r_monto  <= w_monto_n;
         r_dstb   <= w_dstb_n;
         r_mstb   <= w_mstb_n;
         r_err    <= w_err_n;
      end
   end

   assign Digito      = r_digito;
   assign Digito_STB  = r_dstb;
   assign Tipo_trans  = r_tipo;
   assign Monto       = r_monto;
   assign Monto_STB   = r_mstb;
   assign Error_tecla = r_err;

endmodule
`default_nettype wire

// File: doc/teclado_atm.md
# teclado_atm

Keypad front-end for the ATM controller. It synchronises and debounces a raw 4-bit keypad code and key-pressed level. In PIN entry it forwards each accepted digit as `Digito` with a one-cycle `Digito_STB`. It decodes the transaction keys into `Tipo_trans`, accumulates decimal amounts, and delivers them as `Monto` with a one-cycle `Monto_STB`, directly feeding those controller inputs.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive identical synchronised samples required to accept a press or a release; legal range 1..255.
- `MAX_DIGITOS`, default 9: maximum decimal digits in an amount; legal range 1..9, so the value always fits in 32 bits.
- `CLK`  in  1  single clock; all state is updated on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Tecla`  in  4  raw key code from the keypad: 0x0–0x9 digits, 0xA depósito, 0xB retiro, 0xC borrar, 0xD cancelar, 0xE enter, 0xF unused.
- `Tecla_presionada`  in  1  raw key-down level; asynchronous and bouncing.
- `Tarjeta_recibida`  in  1  card present; when low, all keys are ignored.
- `Bloqueo`  in  1  controller lockout; while high, accepted keys are silently discarded.
- `Digito`  out  4  last forwarded PIN digit; holds its value between strobes.
- `Digito_STB`  out  1  one-cycle pulse; `Digito` is valid in the same cycle.
- `Tipo_trans`  out  1  0 = depósito, 1 = retiro; a level that holds until changed.
- `Monto`  out  32  last entered amount in binary; holds its value between strobes.
- `Monto_STB`  out  1  one-cycle pulse; `Monto` is valid in the same cycle.
- `Error_tecla`  out  1  one-cycle pulse on a rejected key.

## Operation
- Input path: two-flop synchroniser on `Tecla` and on `Tecla_presionada`, then the debouncer.
- Debouncer has two phases:
  - Armed: counts consecutive synchronised samples with pressed=1 and an unchanged code. A code change or pressed=0 reloads the count to 0. When the count reaches `DEBOUNCE_CYCLES`, the key is accepted exactly once and the debouncer goes to released-wait.
  - Released-wait: needs `DEBOUNCE_CYCLES` consecutive pressed=0 samples before re-arming. Holding a key down never repeats it.
- State `ESPERA` (reset state): all keys are ignored. When `Tarjeta_recibida`=1, go to `DIGITOS`.
- State `DIGITOS`:
  - Digit: `Digito` ← code, pulse `Digito_STB`.
  - A/B: `Tipo_trans` ← 0/1, clear the accumulator and digit count, go to `MONTO`.
  - C/D/E/F: pulse `Error_tecla`.
- State `MONTO`:
  - Digit with count < `MAX_DIGITOS`: acc ← acc×10 + d, count+1.
  - Digit with count = `MAX_DIGITOS`: pulse `Error_tecla`; acc is unchanged.
  - C: acc ← 0, count ← 0; stay in `MONTO`.
  - D: clear acc and count, go to `DIGITOS`; `Monto` is not touched.
  - E with count ≥ 1: `Monto` ← acc, pulse `Monto_STB`, clear acc and count, go to `DIGITOS`.
  - E with count = 0: pulse `Error_tecla`; stay in `MONTO`.
  - A/B: pulse `Error_tecla`; `Tipo_trans` is unchanged.
  - F: pulse `Error_tecla`.
- `Tarjeta_recibida`=0 in any state: go to `ESPERA` next edge and clear acc and count. A key accepted in that same cycle is dropped with no strobe and no error.
- `Bloqueo`=1: accepted keys are discarded with no strobe and no error; state and acc are unchanged.
- At most one of `Digito_STB`, `Monto_STB`, `Error_tecla` is high in any cycle.

## Timing
- Reset value of every output is 0: `Digito`=0, `Digito_STB`=0, `Tipo_trans`=0, `Monto`=0, `Monto_STB`=0, `Error_tecla`=0.
- Reset also clears the FSM (to `ESPERA`), acc, count, debouncer and synchronisers. This takes effect immediately, including mid-debounce or mid-amount.
- Latency: the raw press is first sampled high at edge k and stays stable. The resulting strobe is registered at edge k+`DEBOUNCE_CYCLES`+1 and is high for exactly one cycle.
- Register updates land on the same edge as their strobe:
  - `Digito` updates with `Digito_STB`.
  - `Monto` updates with `Monto_STB`.
  - `Tipo_trans` updates on the acceptance edge of A/B, well before any `Monto_STB`.
- Release to next possible acceptance: minimum 2×`DEBOUNCE_CYCLES` synchronised samples.
- A bounce shorter than `DEBOUNCE_CYCLES` samples produces no event.

## Test plan
- Reset, card=1, key 0x8 held 10 cycles (D=4): exactly one `Digito_STB`, registered at edge k+5, with `Digito`=8; no repeat while held.
- Key 0x3 pressed for 2 cycles, then key 0x5 held stable: only `Digito`=5 is produced; 0x3 is rejected as a bounce.
- B, 1, 2, 7, E: `Tipo_trans`=1, then `Monto`=127 with a one-cycle `Monto_STB`; FSM returns to `DIGITOS`.
- A, 9, C, 4, 0, E: `Tipo_trans`=0 and `Monto`=40. Then A, E: `Error_tecla` pulse, no `Monto_STB`, `Monto` stays 40.
- A, then ten 9s, then E (`MAX_DIGITOS`=9): the tenth 9 pulses `Error_tecla`; `Monto`=999999999.
- Enter 5 in `MONTO`, drop card to 0, raise card to 1, then A, E: `Error_tecla` on E (acc was cleared). Also `Bloqueo`=1 during digit 7: no strobe at all. Also `Reset` mid-hold: all outputs 0 and no strobe.
